// File: rtl/pipelined_loa_adder.sv
// ---------------------------------------------------------------------------
// pipelined_loa_adder
//
// Lower-part-OR approximate adder with a pipelined carry chain. For each beat
// the lowest k bits of the sum are replaced by a bitwise OR of the operands
// (k = approx_k_i, saturated at APPROX_MAX). The remaining upper bits form an
// exact ripple sum whose carry-in is the AND of the operand bits just below
// the approximated region. An exact sum is computed alongside so exact_o can
// flag beats where the approximation happened to be correct.
//
// The carry chain is cut into STAGES equal slices. Each pipeline register
// holds the operands, the approximation mask, the partial sums computed so
// far and both running carries. All stages advance together under a single
// stall signal driven by the output handshake.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset, empties the pipeline
//   in_valid_i   operand beat valid
//   in_ready_o   block accepts a beat this cycle
//   add1_i       operand A (WIDTH bits)
//   add2_i       operand B (WIDTH bits)
//   approx_k_i   number of low bits to OR-approximate for this beat
//   out_valid_o  result beat valid
//   out_ready_i  downstream consumes the result this cycle
//   result_o     approximate sum, MSB is the carry-out (WIDTH+1 bits)
//   exact_o      result_o equals the true sum of the beat
// ---------------------------------------------------------------------------
module pipelined_loa_adder #(
    parameter int WIDTH      = 16,
    parameter int APPROX_MAX = 8,
    parameter int STAGES     = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [WIDTH-1:0]                  add1_i,
    input  logic [WIDTH-1:0]                  add2_i,
    input  logic [$clog2(APPROX_MAX+1)-1:0]   approx_k_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [WIDTH:0]                    result_o,
    output logic                              exact_o
);

    localparam int KW    = $clog2(APPROX_MAX + 1);
    localparam int SLICE = WIDTH / STAGES;

    // Saturated k and the per-bit approximation mask of the incoming beat
    logic [KW-1:0]    k_eff;
    logic [WIDTH-1:0] approx_mask;

    // Pipeline registers, stage 1 is fed from the inputs, STAGES drives outputs
    logic             valid_q  [1:STAGES];
    logic [WIDTH-1:0] a_q      [1:STAGES];
    logic [WIDTH-1:0] b_q      [1:STAGES];
    logic [WIDTH-1:0] mask_q   [1:STAGES];
    logic [WIDTH-1:0] asum_q   [1:STAGES];
    logic [WIDTH-1:0] esum_q   [1:STAGES];
    logic             acarry_q [1:STAGES];
    logic             ecarry_q [1:STAGES];

    // View of what each slice works on: slice 0 sees the inputs, slice s the
    // contents of register s
    logic             valid_in  [0:STAGES-1];
    logic [WIDTH-1:0] a_in      [0:STAGES-1];
    logic [WIDTH-1:0] b_in      [0:STAGES-1];
    logic [WIDTH-1:0] mask_in   [0:STAGES-1];
    logic [WIDTH-1:0] asum_in   [0:STAGES-1];
    logic [WIDTH-1:0] esum_in   [0:STAGES-1];
    logic             acarry_in [0:STAGES-1];
    logic             ecarry_in [0:STAGES-1];

    // Slice results, loaded into the following register
    logic [WIDTH-1:0] nxt_asum   [0:STAGES-1];
    logic [WIDTH-1:0] nxt_esum   [0:STAGES-1];
    logic             nxt_acarry [0:STAGES-1];
    logic             nxt_ecarry [0:STAGES-1];

    logic             adv;

    // Clamp k and expand it into a thermometer mask of approximated bits
    always_comb begin
        k_eff = (approx_k_i > KW'(APPROX_MAX)) ? KW'(APPROX_MAX) : approx_k_i;
        approx_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            approx_mask[i] = (i < int'(k_eff));
        end
    end

    // Route the inputs into slice 0 and each register into the next slice
    always_comb begin
        valid_in[0]  = in_valid_i;
        a_in[0]      = add1_i;
        b_in[0]      = add2_i;
        mask_in[0]   = approx_mask;
        asum_in[0]   = '0;
        esum_in[0]   = '0;
        acarry_in[0] = 1'b0;
        ecarry_in[0] = 1'b0;
        for (int s = 1; s < STAGES; s++) begin
            valid_in[s]  = valid_q[s];
            a_in[s]      = a_q[s];
            b_in[s]      = b_q[s];
            mask_in[s]   = mask_q[s];
            asum_in[s]   = asum_q[s];
            esum_in[s]   = esum_q[s];
            acarry_in[s] = acarry_q[s];
            ecarry_in[s] = ecarry_q[s];
        end
    end

    // One ripple slice per stage. Inside the approximated region the sum bit
    // is a plain OR and no carry propagates, except at the topmost
    // approximated bit, which hands A&B upward as the carry into bit k. The
    // exact chain runs in parallel so the beat can be tagged exact or not.
    always_comb begin
        logic             ac;
        logic             ec;
        logic             abit;
        logic             bbit;
        logic [WIDTH-1:0] mask_above;
        int               idx;
        ac         = 1'b0;
        ec         = 1'b0;
        abit       = 1'b0;
        bbit       = 1'b0;
        mask_above = '0;
        idx        = 0;
        for (int s = 0; s < STAGES; s++) begin
            nxt_asum[s] = asum_in[s];
            nxt_esum[s] = esum_in[s];
            ac          = acarry_in[s];
            ec          = ecarry_in[s];
            mask_above  = mask_in[s] >> 1;
            for (int j = 0; j < SLICE; j++) begin
                idx  = s * SLICE + j;
                abit = a_in[s][idx];
                bbit = b_in[s][idx];
                if (mask_in[s][idx]) begin
                    nxt_asum[s][idx] = abit | bbit;
                    ac               = abit & bbit & ~mask_above[idx];
                end else begin
                    nxt_asum[s][idx] = abit ^ bbit ^ ac;
                    ac               = (abit & bbit) | (ac & (abit ^ bbit));
                end
                nxt_esum[s][idx] = abit ^ bbit ^ ec;
                ec               = (abit & bbit) | (ec & (abit ^ bbit));
            end
            nxt_acarry[s] = ac;
            nxt_ecarry[s] = ec;
        end
    end

    // Whole pipeline moves as one; it only stalls when the last stage holds a
    // result that downstream is refusing. Bubbles ride along as invalid
    // stages, and reset clears data as well so outputs read zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 1; s <= STAGES; s++) begin
                valid_q[s]  <= 1'b0;
                a_q[s]      <= '0;
                b_q[s]      <= '0;
                mask_q[s]   <= '0;
                asum_q[s]   <= '0;
                esum_q[s]   <= '0;
                acarry_q[s] <= 1'b0;
                ecarry_q[s] <= 1'b0;
            end
        end else if (adv) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s+1]  <= valid_in[s];
                a_q[s+1]      <= a_in[s];
                b_q[s+1]      <= b_in[s];
                mask_q[s+1]   <= mask_in[s];
                asum_q[s+1]   <= nxt_asum[s];
                esum_q[s+1]   <= nxt_esum[s];
                acarry_q[s+1] <= nxt_acarry[s];
                ecarry_q[s+1] <= nxt_ecarry[s];
            end
        end
    end

    assign out_valid_o = valid_q[STAGES];
    assign adv         = ~out_valid_o | out_ready_i;
    assign in_ready_o  = adv;
    assign result_o    = {acarry_q[STAGES], asum_q[STAGES]};

    // Only a valid beat can be flagged exact, which also keeps it low in reset
    assign exact_o = valid_q[STAGES] &
                     ({acarry_q[STAGES], asum_q[STAGES]} == {ecarry_q[STAGES], esum_q[STAGES]});

endmodule

// File: tb/tb_pipelined_loa_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_loa_adder
//
// Scoreboard bench for pipelined_loa_adder (WIDTH=16, APPROX_MAX=8,
// STAGES=2). The driver pushes the reference result of every accepted beat
// into a queue; an independent monitor pops and compares whenever the DUT
// hands over a result. Directed sequences cover latency, stalls, throughput
// and reset; a random phase exercises random operands, k and out_ready.
// ---------------------------------------------------------------------------
module tb_pipelined_loa_adder;

    localparam int WIDTH      = 16;
    localparam int APPROX_MAX = 8;
    localparam int STAGES     = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] add1;
    logic [15:0] add2;
    logic [3:0]  approx_k;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] result;
    logic        exact;

    // Expected {exact, result} per accepted beat, in acceptance order
    logic [17:0] exp_q[$];
    int          checks;
    int          errors;
    int          popped;
    bit          random_ready;

    pipelined_loa_adder #(
        .WIDTH(WIDTH),
        .APPROX_MAX(APPROX_MAX),
        .STAGES(STAGES)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .add1_i(add1),
        .add2_i(add2),
        .approx_k_i(approx_k),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o(result),
        .exact_o(exact)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model in plain arithmetic: OR the low k bits, add the shifted
    // upper parts with the carry taken from bit k-1
    function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] k_in);
        int ia;
        int ib;
        int k;
        int low_mask;
        int cin;
        int high;
        int res;
        bit is_exact;
        ia       = int'(a);
        ib       = int'(b);
        k        = (int'(k_in) > APPROX_MAX) ? APPROX_MAX : int'(k_in);
        low_mask = (1 << k) - 1;
        cin      = 0;
        if (k > 0) cin = (ia >> (k - 1)) & (ib >> (k - 1)) & 1;
        high     = (ia >> k) + (ib >> k) + cin;
        res      = (high << k) | ((ia | ib) & low_mask);
        is_exact = (res == ia + ib);
        return {is_exact, 17'(res)};
    endfunction

    // Single comparison point; every check goes through here
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one beat from a negedge until accepted; returns on the negedge
    // after acceptance with in_valid dropped
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] k);
        int tries;
        bit done;
        tries    = 0;
        done     = 1'b0;
        add1     = a;
        add2     = b;
        approx_k = k;
        in_valid = 1'b1;
        while (!done) begin
            if (random_ready) out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready) begin
                exp_q.push_back(refModel(a, b, k));
                done = 1'b1;
            end else if (tries >= 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout got in_ready 0 expected 1 within 200 cycles");
                done = 1'b1;
            end
            tries++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty; ends on a negedge
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: a result is handed over on the coming edge when valid & ready
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output got result 0x%0h expected no beat", result);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_result", 32'(result), 32'(e[16:0]));
                    checkOutput("sb_exact", 32'(exact), 32'(e[17]));
                    popped++;
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        int base;
        checks       = 0;
        errors       = 0;
        popped       = 0;
        random_ready = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        add1         = '0;
        add2         = '0;
        approx_k     = '0;

        // Reset state
        #3;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_exact", 32'(exact), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Approximated beat with exact latency check
        $display("[TB] directed: k=4 approximation and latency");
        applyStimulus(16'h000F, 16'h0008, 4'd4);
        #1;
        checkOutput("latency_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("latency_on_time", 32'(out_valid), 32'd1);
        checkOutput("k4_result", 32'(result), 32'h0001F);
        checkOutput("k4_exact", 32'(exact), 32'd0);
        @(negedge clk);

        // k=0 exact sum with carry-out, and k saturating at APPROX_MAX
        $display("[TB] directed: k=0 and k saturation");
        applyStimulus(16'hFFFF, 16'h0001, 4'd0);
        applyStimulus(16'h00FF, 16'h0080, 4'd15);
        waitDrain("drain_k_edges");

        // Back-to-back throughput: six results in six consecutive cycles
        $display("[TB] directed: back-to-back throughput");
        base = popped;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i * 16'h0101), 4'(i));
        end
        @(negedge clk);
        #3;
        checkOutput("throughput_count", 32'(popped - base), 32'd6);
        @(negedge clk);

        // Stall: two beats held, third refused until downstream is ready
        $display("[TB] directed: output stall");
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h4321, 4'd3);
        applyStimulus(16'hF0F0, 16'h0F0F, 4'd8);
        add1     = 16'hAAAA;
        add2     = 16'h5555;
        approx_k = 4'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_hold_result", 32'(result), 32'(refModel(16'h1234, 16'h4321, 4'd3) & 18'h1FFFF));
            @(negedge clk);
        end
        out_ready = 1'b1;
        applyStimulus(16'hAAAA, 16'h5555, 4'd2);
        waitDrain("drain_stall");

        // Reset with two beats in flight discards them
        $display("[TB] directed: reset mid-flight");
        out_ready = 1'b0;
        applyStimulus(16'h7777, 16'h1111, 4'd1);
        applyStimulus(16'h0101, 16'h1010, 4'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_result", 32'(result), 32'd0);
        checkOutput("midreset_exact", 32'(exact), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("post_reset_idle", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        applyStimulus(16'h8000, 16'h8000, 4'd0);
        #1;
        checkOutput("post_reset_latency_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("post_reset_latency_on_time", 32'(out_valid), 32'd1);
        @(negedge clk);
        waitDrain("drain_post_reset");

        // Random operands, k and downstream backpressure
        $display("[TB] random phase");
        random_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            if ($urandom_range(0, 3) == 0) begin
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) rb = ~ra;
            applyStimulus(ra, rb, 4'($urandom_range(0, 15)));
        end
        random_ready = 1'b0;
        out_ready    = 1'b1;
        waitDrain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_loa_adder.md
PIPELINED_LOA_ADDER -- requirements
Module: pipelined_loa_adder

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand width in bits (>=4).
REQ-002 Parameter APPROX_MAX, default 8, sets the largest number of low bits that can be OR-approximated (1..WIDTH-1).
REQ-003 Parameter STAGES, default 2, sets the number of pipeline register stages (1..4, divides WIDTH).
REQ-004 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 in_valid_i  in  1  operand beat valid.
REQ-007 in_ready_o  out  1  block accepts a beat this cycle.
REQ-008 add1_i  in  WIDTH  operand A.
REQ-009 add2_i  in  WIDTH  operand B.
REQ-010 approx_k_i  in  clog2(APPROX_MAX+1)  per-beat count of approximated low bits.
REQ-011 out_valid_o  out  1  result beat valid.
REQ-012 out_ready_i  in  1  downstream consumes the result this cycle.
REQ-013 result_o  out  WIDTH+1  approximate sum, MSB is the carry-out.
REQ-014 exact_o  out  1  result_o equals the true sum A+B.

Function
REQ-015 The block SHALL accept a beat when in_valid_i and in_ready_o are both 1; approx_k_i SHALL be captured with that beat.
REQ-016 Let k = min(approx_k_i, APPROX_MAX); any approx_k_i above APPROX_MAX SHALL be treated as APPROX_MAX.
REQ-017 For bits i < k: result_o[i] = add1_i[i] | add2_i[i].
REQ-018 Bits k..WIDTH-1 SHALL form an exact ripple sum; the carry into bit k is add1_i[k-1] & add2_i[k-1] when k>0, and 0 when k=0.
REQ-019 result_o[WIDTH] SHALL be the carry-out of bit WIDTH-1.
REQ-020 k=0 SHALL produce the exact sum.
REQ-021 exact_o SHALL be 1 iff result_o equals the zero-extended sum add1_i+add2_i of the same beat.
REQ-022 The carry chain SHALL be split into STAGES equal slices: one slice per stage, with the carry and the remaining operand bits registered between stages.
REQ-023 Latency: an accepted beat SHALL appear on out_valid_o exactly STAGES cycles after acceptance when the pipeline is not stalled.
REQ-024 Throughput SHALL be one beat per cycle while out_ready_i=1.
REQ-025 The pipeline SHALL advance all stages together when adv = ~out_valid_o | out_ready_i.
REQ-026 in_ready_o SHALL equal adv; the pipeline holds when adv=0.
REQ-027 Bubbles SHALL travel as invalid stages and need not be collapsed.
REQ-028 While out_valid_o=1 and out_ready_i=0, result_o, exact_o and all stage contents SHALL hold stable.
REQ-029 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-030 Acceptance and output consumption in the same cycle SHALL both take effect.
REQ-031 When in_valid_i=0 on an advancing cycle, stage 1 SHALL be loaded invalid.
REQ-032 Operand and k values SHALL be ignored when the beat is not accepted.

Reset
REQ-033 rst_ni=0 SHALL, asynchronously, clear all stage valid bits, making out_valid_o=0.
REQ-034 During reset, result_o and exact_o SHALL be 0.
REQ-035 During reset, in_ready_o SHALL be 1, since it follows from out_valid_o=0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight beats; no beat accepted before reset SHALL emerge afterwards.
REQ-037 The first beat accepted after deassertion SHALL follow REQ-023.

Verification (WIDTH=16, APPROX_MAX=8, STAGES=2)
REQ-038 k=4, A=0x000F, B=0x0008 -> after 2 cycles result_o=0x0001F, exact_o=0 (true sum 0x00017).
REQ-039 k=0, A=0xFFFF, B=0x0001 -> result_o=0x10000, exact_o=1; k=15 with A=0x00FF, B=0x0080 -> behaves as k=8: result_o=0x001FF, exact_o=0.
REQ-040 Back-to-back beats with out_ready_i=1 -> one result per cycle in order, 2-cycle latency each.
REQ-041 Three beats sent with out_ready_i=0 -> two beats held, in_ready_o=0 while stalled, result_o stable; out_ready_i=1 then drains them in order, after which the third beat is accepted and delivered.
REQ-042 rst_ni pulsed low with 2 beats in flight -> out_valid_o=0 immediately; no stale result appears after release.
REQ-043 Random A, B and k against a reference model -> result_o and exact_o match for every beat, including under random out_ready_i.
